// File: rtl/clock_display_scan_pkg.sv
// Shared constants and types for the six-digit multiplexed clock display.
package clock_display_scan_pkg;

    localparam int unsigned NUM_DIGITS = 6;
    localparam int unsigned DIGIT_W    = 3;
    localparam int unsigned BCD_W      = 4;
    localparam int unsigned SEG_W      = 7;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    typedef struct packed {
        logic [BCD_W-1:0] h1;
        logic [BCD_W-1:0] h0;
        logic [BCD_W-1:0] m1;
        logic [BCD_W-1:0] m0;
        logic [BCD_W-1:0] s1;
        logic [BCD_W-1:0] s0;
    } time_bcd_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD digit to active-low seven-segment decoder; non-decimal codes show a dash.
module bcd_to_seg7
    import clock_display_scan_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [SEG_W-1:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/clock_display_scan.sv
// Time-multiplexed HH.MM.SS display scanner with per-frame snapshot,
// anti-ghost blanking and alarm blink.
module clock_display_scan
    import clock_display_scan_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 1000,
    parameter int unsigned BLANK_CYC   = 50,
    parameter int unsigned BLINK_DIV   = 500000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             Hour_in1,
    input  logic [BCD_W-1:0]       Hour_in0,
    input  logic [BCD_W-1:0]       Minute_in1,
    input  logic [BCD_W-1:0]       Minute_in0,
    input  logic [BCD_W-1:0]       Second_in1,
    input  logic [BCD_W-1:0]       Second_in0,
    input  logic                   Alarm,
    output logic [NUM_DIGITS-1:0]  an,
    output logic [SEG_W-1:0]       seg,
    output logic                   dp
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned BLK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    if (REFRESH_DIV < 2) begin : g_bad_refresh_div
        $error("REFRESH_DIV must be 2 or more");
    end
    if (BLANK_CYC >= REFRESH_DIV) begin : g_bad_blank_cyc
        $error("BLANK_CYC must be below REFRESH_DIV");
    end
    if (BLINK_DIV < 2) begin : g_bad_blink_div
        $error("BLINK_DIV must be 2 or more");
    end

    logic [CNT_W-1:0]   slot_cnt;
    logic [DIGIT_W-1:0] digit_idx;
    logic [BLK_W-1:0]   blink_cnt;
    logic               blink_phase;
    time_bcd_t          snap;

    logic               slot_last_c;
    logic               digit_last_c;
    logic               blink_last_c;
    logic               frame_start_c;
    logic               in_blank_c;
    time_bcd_t          live_c;
    time_bcd_t          view_c;
    logic [BCD_W-1:0]   digit_bcd_c;
    logic [SEG_W-1:0]   seg_c;
    logic [NUM_DIGITS-1:0] an_c;
    logic               dp_c;

    assign slot_last_c   = (slot_cnt == CNT_W'(REFRESH_DIV - 1));
    assign digit_last_c  = (digit_idx == DIGIT_W'(NUM_DIGITS - 1));
    assign blink_last_c  = (blink_cnt == BLK_W'(BLINK_DIV - 1));
    assign frame_start_c = (digit_idx == '0) && (slot_cnt == '0);
    assign in_blank_c    = (32'(slot_cnt) < BLANK_CYC);

    // The frame's first slot shows the values being captured, so every slot
    // of a frame (including its very first) sees the same coherent time.
    always_comb begin
        live_c = '{h1: {2'b00, Hour_in1}, h0: Hour_in0, m1: Minute_in1,
                   m0: Minute_in0, s1: Second_in1, s0: Second_in0};
        view_c = frame_start_c ? live_c : snap;
    end

    always_comb begin
        digit_bcd_c = '0;
        case (digit_idx)
            3'd0:    digit_bcd_c = view_c.s0;
            3'd1:    digit_bcd_c = view_c.s1;
            3'd2:    digit_bcd_c = view_c.m0;
            3'd3:    digit_bcd_c = view_c.m1;
            3'd4:    digit_bcd_c = view_c.h0;
            3'd5:    digit_bcd_c = view_c.h1;
            default: digit_bcd_c = '0;
        endcase
    end

    bcd_to_seg7 u_dec (
        .bcd (digit_bcd_c),
        .seg (seg_c)
    );

    always_comb begin
        an_c = '1;
        if (!in_blank_c && !blink_phase) begin
            an_c = ~(NUM_DIGITS'(1) << digit_idx);
        end
        dp_c = !(((digit_idx == 3'd2) || (digit_idx == 3'd4)) && !view_c.s0[0]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt    <= '0;
            digit_idx   <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            snap        <= '0;
            an          <= '1;
            seg         <= SEG_BLANK;
            dp          <= 1'b1;
        end else begin
            if (slot_last_c) begin
                slot_cnt  <= '0;
                digit_idx <= digit_last_c ? '0 : digit_idx + DIGIT_W'(1);
            end else begin
                slot_cnt  <= slot_cnt + CNT_W'(1);
            end

            if (frame_start_c) begin
                snap <= live_c;
            end

            // Blink runs only while the alarm is up; dropping it clears at once
            if (Alarm) begin
                if (blink_last_c) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt   <= blink_cnt + BLK_W'(1);
                end
            end else begin
                blink_cnt   <= '0;
                blink_phase <= 1'b0;
            end

            an  <= an_c;
            seg <= seg_c;
            dp  <= dp_c;
        end
    end

endmodule
